// File: rtl/muldiv_seq_ctrl_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer: funct3 codes,
// unit control words, FSM states and result-correction classes.
package muldiv_seq_ctrl_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [3:0] ACL_MUL_LO = 4'b0000;
  localparam logic [3:0] ACL_MUL_HI = 4'b0001;
  localparam logic [3:0] ACL_DIV    = 4'b0100;
  localparam logic [3:0] ACL_REM    = 4'b0110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN_LO,
    ST_RUN_HI,
    ST_RUN_DIV,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    OPC_PLAIN,
    OPC_MULHS,
    OPC_QUO,
    OPC_REM
  } op_class_e;

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_seq_ctrl_if.sv
// Core-side request/response bundle between execute/writeback and the
// multiply/divide sequencer.
interface muldiv_seq_ctrl_if;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  modport master (
    output start, flush, funct3, rs1, rs2, rd_in,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, flush, funct3, rs1, rs2, rd_in,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Turns the unsigned unit result back into the signed RV32M answer using the
// operand sign flags captured at accept.
module muldiv_sign_fix
  import muldiv_seq_ctrl_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [31:0] lo_i,
  input  logic        neg1_i,
  input  logic        neg2_i,
  input  op_class_e   cls_i,
  output logic [31:0] res_o
);

  always_comb begin
    res_o = raw_i;
    case (cls_i)
      // Negating a 64-bit product: high word gets the carry only when low word is zero
      OPC_MULHS: if (neg1_i ^ neg2_i) res_o = ~raw_i + {31'd0, (lo_i == 32'd0)};
      OPC_QUO:   if (neg1_i ^ neg2_i) res_o = 32'd0 - raw_i;
      OPC_REM:   if (neg1_i)          res_o = 32'd0 - raw_i;
      default:   res_o = raw_i;
    endcase
  end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// RV32M sequencer in front of an unsigned combinational mul/div unit: holds
// magnitudes on the unit for SETTLE_CYCLES per phase, then sign-corrects.
//
// state      | meaning
// ST_IDLE    | waiting for start
// ST_RUN_LO  | unit computing low product word
// ST_RUN_HI  | unit computing high product word
// ST_RUN_DIV | unit computing quotient or remainder
// ST_DONE    | result registered, done pulse
module muldiv_seq_ctrl
  import muldiv_seq_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  muldiv_seq_ctrl_if.slave core_if,
  output logic [31:0]      mu_a_o,
  output logic [31:0]      mu_b_o,
  output logic [3:0]       mu_acl_o,
  input  logic [31:0]      mu_result_i
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  op_class_e   cls_q, cls_d;
  logic        neg1_q, neg1_d, neg2_q, neg2_d;
  logic [4:0]  rd_q, rd_d, rd_out_q, rd_out_d;
  logic [31:0] mu_a_q, mu_a_d, mu_b_q, mu_b_d;
  logic [3:0]  acl_q, acl_d;
  logic [31:0] lo_q, lo_d, result_q, result_d;

  logic        acc_s1, acc_s2, acc_bypass;
  op_class_e   acc_cls;
  logic [3:0]  acc_acl;
  state_e      acc_st;
  logic [31:0] acc_bypass_val, fixed;

  always_comb begin
    acc_s1  = 1'b0;
    acc_s2  = 1'b0;
    acc_cls = OPC_PLAIN;
    acc_acl = ACL_MUL_LO;
    acc_st  = ST_RUN_LO;
    case (core_if.funct3)
      F3_MUL:    ;
      F3_MULH:   begin acc_s1 = 1'b1; acc_s2 = 1'b1; acc_cls = OPC_MULHS; end
      F3_MULHSU: begin acc_s1 = 1'b1; acc_cls = OPC_MULHS; end
      F3_MULHU:  begin acc_acl = ACL_MUL_HI; acc_st = ST_RUN_HI; end
      F3_DIV:    begin acc_s1 = 1'b1; acc_s2 = 1'b1; acc_cls = OPC_QUO; acc_acl = ACL_DIV; acc_st = ST_RUN_DIV; end
      F3_DIVU:   begin acc_cls = OPC_QUO; acc_acl = ACL_DIV; acc_st = ST_RUN_DIV; end
      F3_REM:    begin acc_s1 = 1'b1; acc_s2 = 1'b1; acc_cls = OPC_REM; acc_acl = ACL_REM; acc_st = ST_RUN_DIV; end
      F3_REMU:   begin acc_cls = OPC_REM; acc_acl = ACL_REM; acc_st = ST_RUN_DIV; end
      default:   ;
    endcase
  end

  // Divide-by-zero and signed overflow never reach the unit; funct3[1] picks REM vs DIV
  always_comb begin
    acc_bypass     = 1'b0;
    acc_bypass_val = 32'd0;
    if (core_if.funct3[2] && (core_if.rs2 == 32'd0)) begin
      acc_bypass     = 1'b1;
      acc_bypass_val = core_if.funct3[1] ? core_if.rs1 : 32'hFFFF_FFFF;
    end else if (((core_if.funct3 == F3_DIV) || (core_if.funct3 == F3_REM)) &&
                 (core_if.rs1 == 32'h8000_0000) && (core_if.rs2 == 32'hFFFF_FFFF)) begin
      acc_bypass     = 1'b1;
      acc_bypass_val = core_if.funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  muldiv_sign_fix u_sign_fix (
    .raw_i  (mu_result_i),
    .lo_i   (lo_q),
    .neg1_i (neg1_q),
    .neg2_i (neg2_q),
    .cls_i  (cls_q),
    .res_o  (fixed)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cls_d    = cls_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    mu_a_d   = mu_a_q;
    mu_b_d   = mu_b_q;
    acl_d    = acl_q;
    lo_d     = lo_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (core_if.start && !core_if.flush) begin
          rd_d   = core_if.rd_in;
          cls_d  = acc_cls;
          neg1_d = acc_s1 & core_if.rs1[31];
          neg2_d = acc_s2 & core_if.rs2[31];
          if (acc_bypass) begin
            state_d  = ST_DONE;
            result_d = acc_bypass_val;
            rd_out_d = core_if.rd_in;
          end else begin
            mu_a_d  = magnitude(core_if.rs1, acc_s1);
            mu_b_d  = magnitude(core_if.rs2, acc_s2);
            acl_d   = acc_acl;
            state_d = acc_st;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_RUN_LO, ST_RUN_HI, ST_RUN_DIV: begin
        if (core_if.flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if ((state_q == ST_RUN_LO) && (cls_q == OPC_MULHS)) begin
          lo_d    = mu_result_i;
          acl_d   = ACL_MUL_HI;
          state_d = ST_RUN_HI;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d  = ST_DONE;
          result_d = fixed;
          rd_out_d = rd_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cls_q    <= OPC_PLAIN;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      rd_q     <= 5'd0;
      rd_out_q <= 5'd0;
      mu_a_q   <= 32'd0;
      mu_b_q   <= 32'd0;
      acl_q    <= ACL_MUL_LO;
      lo_q     <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cls_q    <= cls_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      mu_a_q   <= mu_a_d;
      mu_b_q   <= mu_b_d;
      acl_q    <= acl_d;
      lo_q     <= lo_d;
      result_q <= result_d;
    end
  end

  assign core_if.busy   = (state_q == ST_RUN_LO) || (state_q == ST_RUN_HI) || (state_q == ST_RUN_DIV);
  assign core_if.done   = (state_q == ST_DONE) && !core_if.flush;
  assign core_if.result = result_q;
  assign core_if.rd_out = rd_out_q;
  assign mu_a_o         = mu_a_q;
  assign mu_b_o         = mu_b_q;
  assign mu_acl_o       = acl_q;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Scoreboard bench for muldiv_seq_ctrl with a behavioural unsigned mul/div unit.
module tb_muldiv_seq_ctrl;
  import muldiv_seq_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] mu_a, mu_b, mu_result;
  logic [3:0]  mu_acl;
  logic [63:0] prod;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
    logic        chk_acl;
    logic [3:0]  acl;
    int          e0;
  } exp_t;
  exp_t sb[$];

  muldiv_seq_ctrl_if bus();

  muldiv_seq_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .core_if     (bus),
    .mu_a_o      (mu_a),
    .mu_b_o      (mu_b),
    .mu_acl_o    (mu_acl),
    .mu_result_i (mu_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign prod = {32'd0, mu_a} * {32'd0, mu_b};
  always_comb begin
    mu_result = 32'd0;
    case (mu_acl)
      4'b0000: mu_result = prod[31:0];
      4'b0001: mu_result = prod[63:32];
      4'b0100: mu_result = (mu_b == 32'd0) ? 32'hFFFF_FFFF : mu_a / mu_b;
      4'b0110: mu_result = (mu_b == 32'd0) ? mu_a : mu_a % mu_b;
      default: mu_result = 32'd0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected entry
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", bus.result, e.res);
        chk("rd_out", {27'd0, bus.rd_out}, {27'd0, e.rd});
        chk("latency", 32'(cyc + 1 - e.e0), 32'(e.lat));
        if (e.chk_acl) chk("mu_acl", {28'd0, mu_acl}, {28'd0, e.acl});
      end
    end
    if (bus.busy === 1'b1 && (mu_acl == ACL_DIV || mu_acl == ACL_REM))
      chk("div_operand_nonzero", {31'd0, (mu_b == 32'd0)}, 32'd0);
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat,
                       input logic chk_acl, input logic [3:0] acl);
    bit got;
    exp_t e;
    @(negedge clk);
    bus.funct3 = f3;
    bus.rs1    = a;
    bus.rs2    = b;
    bus.rd_in  = rd;
    bus.start  = 1'b1;
    e.res = exp; e.rd = rd; e.lat = lat; e.chk_acl = chk_acl; e.acl = acl; e.e0 = cyc + 1;
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) got = 1'b1;
    end
    bus.start = 1'b0;
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = 3'd0;
    bus.rs1    = 32'd0;
    bus.rs2    = 32'd0;
    bus.rd_in  = 5'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
    chk("rst_done",   {31'd0, bus.done}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_mu_a",   mu_a, 32'd0);
    rst_n = 1'b1;

    issue(F3_MUL,    32'd7,          32'd6,          5'd1,  32'd42,         3, 1'b1, ACL_MUL_LO);
    issue(F3_MULH,   32'h8000_0000,  32'd2,          5'd2,  32'hFFFF_FFFF,  5, 1'b1, ACL_MUL_HI);
    issue(F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd3,  32'd0,          5, 1'b1, ACL_MUL_HI);
    issue(F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd4,  32'hFFFF_FFFE,  3, 1'b1, ACL_MUL_HI);
    issue(F3_MULHSU, 32'hFFFF_FFFF,  32'd2,          5'd5,  32'hFFFF_FFFF,  5, 1'b1, ACL_MUL_HI);
    issue(F3_DIV,    32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFD,  3, 1'b1, ACL_DIV);
    issue(F3_REM,    32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFF,  3, 1'b1, ACL_REM);
    issue(F3_DIVU,   32'hFFFF_FFF9,  32'd2,          5'd8,  32'h7FFF_FFFC,  3, 1'b1, ACL_DIV);
    issue(F3_REMU,   32'hFFFF_FFF9,  32'd2,          5'd9,  32'd1,          3, 1'b1, ACL_REM);
    issue(F3_DIVU,   32'd5,          32'd0,          5'd10, 32'hFFFF_FFFF,  1, 1'b0, 4'd0);
    issue(F3_REMU,   32'd5,          32'd0,          5'd11, 32'd5,          1, 1'b0, 4'd0);
    issue(F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h8000_0000,  1, 1'b0, 4'd0);
    issue(F3_REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'd0,          1, 1'b0, 4'd0);
    issue(F3_DIV,    32'd7,          32'hFFFF_FFFE,  5'd14, 32'hFFFF_FFFD,  3, 1'b1, ACL_DIV);
    issue(F3_REM,    32'd7,          32'hFFFF_FFFE,  5'd15, 32'd1,          3, 1'b1, ACL_REM);
    issue(F3_DIV,    32'd0,          32'd0,          5'd16, 32'hFFFF_FFFF,  1, 1'b0, 4'd0);
    issue(F3_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd17, 32'd1,          3, 1'b1, ACL_MUL_LO);

    // Flush one cycle into MULH: no done, previous result kept
    @(negedge clk);
    bus.funct3 = F3_MULH; bus.rs1 = 32'd9; bus.rs2 = 32'd9; bus.rd_in = 5'd20;
    bus.start  = 1'b1;
    @(negedge clk);
    chk("flush_busy_before", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_idle",   {31'd0, bus.busy}, 32'd0);
    chk("flush_held",   bus.result, 32'd1);
    chk("flush_rd_held", {27'd0, bus.rd_out}, 32'd17);
    repeat (3) @(negedge clk);
    chk("flush_no_done_result", bus.result, 32'd1);
    issue(F3_MUL, 32'd3, 32'd5, 5'd21, 32'd15, 3, 1'b1, ACL_MUL_LO);

    // Asynchronous reset during RUN_DIV
    @(negedge clk);
    bus.funct3 = F3_DIV; bus.rs1 = 32'd100; bus.rs2 = 32'd7; bus.rd_in = 5'd22;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rstmid_busy_before", {31'd0, bus.busy}, 32'd1);
    chk("rstmid_mu_acl_before", {28'd0, mu_acl}, {28'd0, ACL_DIV});
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_busy",   {31'd0, bus.busy}, 32'd0);
    chk("rstmid_result", bus.result, 32'd0);
    chk("rstmid_rd_out", {27'd0, bus.rd_out}, 32'd0);
    chk("rstmid_mu_a",   mu_a, 32'd0);
    chk("rstmid_mu_b",   mu_b, 32'd0);
    chk("rstmid_mu_acl", {28'd0, mu_acl}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstmid_no_done", bus.result, 32'd0);
    issue(F3_MUL, 32'd3, 32'd3, 5'd23, 32'd9, 3, 1'b1, ACL_MUL_LO);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_seq_ctrl.md
Name: muldiv_seq_ctrl

Overview:
- Sequencer that sits directly upstream of the unsigned combinational multiply/divide unit and feeds it.
- Accepts an RV32M op from execute and converts signed operands to magnitudes.
- Drives the unit's operands and 4-bit control, holding them for a configurable multicycle settle window, then captures the unsigned result.
- Applies sign correction and RISC-V corner-case rules, and returns a registered result with a done pulse for writeback.

Parameters:
SETTLE_CYCLES, 2, cycles operands/control are held stable before each capture (min 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  op request; sampled only in IDLE
flush  in  1  abort in-flight op
funct3  in  3  RV32M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU)
rs1  in  32  operand 1
rs2  in  32  operand 2
rd_in  in  5  destination register tag
mu_a  out  32  operand 1 to mul/div unit
mu_b  out  32  operand 2 to mul/div unit
mu_acl  out  4  unit control: 0000 low product, 0001 high product, 0100 quotient, 0110 remainder
mu_result  in  32  unsigned result from unit
busy  out  1  op in flight; core stalls on start|busy
done  out  1  one-cycle pulse, result valid
result  out  32  final signed-corrected result
rd_out  out  5  tag of completed op

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, result=0, rd_out=0, mu_a=0, mu_b=0, mu_acl=0000, counters cleared. Reset mid-op discards the op; no done follows.
- States: IDLE, RUN_LO, RUN_HI, RUN_DIV, DONE. busy=1 in RUN_*; done=1 only in DONE, which is one cycle, then IDLE.
- Accept: edge E0 with IDLE & start & !flush. Latch funct3, rd_in, sign flags, and operand magnitudes into mu_a/mu_b.
- Operand signedness:
  - rs1 signed for MULH, MULHSU, DIV, REM.
  - rs2 signed for MULH, DIV, REM.
  - Magnitude = two's-complement negate if signed and bit31=1; 0x80000000 stays 0x80000000.
- MUL, MULHU: one phase, RUN_LO (acl 0000) or RUN_HI (acl 0001). MUL is sign-agnostic and uses raw operands.
- MULH, MULHSU: RUN_LO captures low word into internal lo, then RUN_HI captures high.
  - If the product is negative (sign flags differ), result = ~hi + (lo==0).
- DIV/DIVU/REM/REMU: RUN_DIV, acl 0100 (quotient) or 0110 (remainder).
  - Quotient negated if sign flags differ.
  - Remainder negated if dividend negative.
- Each RUN phase lasts exactly SETTLE_CYCLES cycles and captures mu_result on its last edge.
- Latency (done high in the cycle after edge):
  - Single-phase ops: E0+SETTLE_CYCLES+1.
  - MULH/MULHSU: E0+2*SETTLE_CYCLES+1.
- Bypass, decided at accept, goes straight to DONE with done at E0+1; the unit is never driven with rs2=0:
  - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- result/rd_out update only on entry to DONE and hold until the next completion.
- start while busy or in DONE is ignored; the requester holds start until it sees done.
- flush in any RUN_* or DONE: next edge -> IDLE, done suppressed, result unchanged. flush with start in IDLE: not accepted.
- All arithmetic is 32-bit modulo; no X propagation from an undriven unit result.

Decomposition:
- Shared package holds:
  - funct3 localparams (F3_MUL … F3_REMU).
  - acl localparams (ACL_MUL_LO=0000, ACL_MUL_HI=0001, ACL_DIV=0100, ACL_REM=0110), matching the unit's encoding.
  - State encoding.
- One natural sub-module: muldiv_sign_fix. It is combinational: takes the captured raw value, lo, the sign flags and op class, and returns the corrected result.

Test Plan:
- MUL rs1=7, rs2=6, SETTLE_CYCLES=2 -> mu_acl=0000, done at E0+3, result=42, rd_out=rd_in.
- MULH rs1=0x80000000, rs2=2 -> two phases, done at E0+5, result=0xFFFFFFFF. MULH 0xFFFFFFFF×0xFFFFFFFF -> 0.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU same operands -> 0x7FFFFFFC.
- DIVU 5/0 -> 0xFFFFFFFF at E0+1. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- flush one cycle into MULH -> IDLE next edge, no done, previous result held. New start accepted the cycle after.
- rst_n low during RUN_DIV -> outputs zero immediately (async). After release, the next MUL 3×3 completes with 9.
